fetch_unit: RTL



---
 rtl/fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests to
// instruction memory within a credit budget of DEPTH, and queues returned
// words with their PCs for decode. A redirect reloads the PC, flushes the
// queue and marks every in-flight response for discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];

  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic [CW:0]   credits_used;
  logic [CW-1:0] outst_next;
  logic [31:0]   target;

  function automatic logic [CW-1:0] ext(input logic b);
    return {{(CW-1){1'b0}}, b};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + ONE_P;
  endfunction

  // Request credits, handshake qualification and FIFO head presentation
  always_comb begin
    credits_used = {1'b0, outst} + {1'b0, count};
    // rst_n gates the request so it drops the instant reset asserts
    imem_req     = rst_n & (credits_used < DEPTH_C);
    imem_addr    = pc;
    grant        = imem_req & imem_gnt;
    resp         = imem_rvalid & (outst != '0);
    outst_next   = outst + ext(grant) - ext(resp);
    push         = resp & ~redirect & (drop == '0);
    if_valid     = (count != '0) & ~redirect;
    pop          = if_valid & if_ready;
    target       = {redirect_pc[31:2], 2'b00};
    if_instr     = fifo_instr[rd_ptr];
    if_pc        = fifo_pc[rd_ptr];
  end

  // PC, credit/drop bookkeeping and FIFO storage; redirect overrides all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      outst <= outst_next;
      if (redirect) begin
        // everything still owed by memory, including this cycle's grant, is stale
        pc      <= target;
        resp_pc <= target;
        drop    <= outst_next;
        count   <= '0;
        rd_ptr  <= wr_ptr;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (resp && (drop != '0)) drop <= drop - ext(1'b1);
        if (push) begin
          fifo_pc[wr_ptr]    <= resp_pc;
          fifo_instr[wr_ptr] <= imem_rdata;
          wr_ptr             <= ptr_inc(wr_ptr);
          resp_pc            <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + ext(push) - ext(pop);
      end
    end
  end

endmodule
